usb_sie_tx: RTL and testbench



---
 rtl/usb_sie_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_usb_sie_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_tx.sv
// Transmit serial interface engine: SYNC, PID, token/data fields, CRC5/CRC16, bit stuffing,
// NRZI and EOP onto the USB pair. Define USB_TX_LOW_SPEED_EN for low-speed line polarity.
module usb_sie_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_BYTES    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             pid,
    input  logic [6:0]             addr,
    input  logic [3:0]             endp,
    input  logic [10:0]            frame,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [3:0]             data_len,
    output logic                   dp_o,
    output logic                   dm_o,
    output logic                   oe,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int CW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DIDX_W = (MAX_BYTES > 1) ? $clog2(8 * MAX_BYTES) : 3;
    localparam int IDX_W  = (DIDX_W > 4) ? DIDX_W : 4;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_LOW_SPEED_EN
    localparam logic LINE_POL = 1'b1;
`else
    localparam logic LINE_POL = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t                   state_reg, state_next;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic [CW-1:0]            clk_cnt_reg, clk_cnt_next;
    logic [2:0]               stuff_cnt_reg, stuff_cnt_next;
    logic                     lvl_reg, lvl_next;   // 1 = J, 0 = K
    logic                     se0_reg, se0_next;
    logic [4:0]               crc5_reg, crc5_next;
    logic [15:0]              crc16_reg, crc16_next;
    logic [3:0]               pid_reg, pid_next;
    logic [10:0]              field_reg, field_next;
    logic [8*MAX_BYTES-1:0]   data_reg, data_next;
    logic [3:0]               len_reg, len_next;
    logic                     done_reg, done_next;
    logic                     error_reg, error_next;

    state_t                   adv_state;
    logic [IDX_W-1:0]         adv_idx;
    logic                     raw_bit;
    logic                     emit_raw;
    logic                     is_bit_state;
    logic [7:0]               pid_byte;

    assign is_bit_state = state_reg inside {S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16};
    assign pid_byte     = {~pid_reg, pid_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            clk_cnt_reg   <= '0;
            stuff_cnt_reg <= '0;
            lvl_reg       <= 1'b1;
            se0_reg       <= 1'b0;
            crc5_reg      <= 5'h1F;
            crc16_reg     <= 16'hFFFF;
            pid_reg       <= '0;
            field_reg     <= '0;
            data_reg      <= '0;
            len_reg       <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            clk_cnt_reg   <= clk_cnt_next;
            stuff_cnt_reg <= stuff_cnt_next;
            lvl_reg       <= lvl_next;
            se0_reg       <= se0_next;
            crc5_reg      <= crc5_next;
            crc16_reg     <= crc16_next;
            pid_reg       <= pid_next;
            field_reg     <= field_next;
            data_reg      <= data_next;
            len_reg       <= len_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        clk_cnt_next   = clk_cnt_reg;
        stuff_cnt_next = stuff_cnt_reg;
        lvl_next       = lvl_reg;
        se0_next       = se0_reg;
        crc5_next      = crc5_reg;
        crc16_next     = crc16_reg;
        pid_next       = pid_reg;
        field_next     = field_reg;
        data_next      = data_reg;
        len_next       = len_reg;
        done_next      = 1'b0;
        error_next     = 1'b0;
        adv_state      = state_reg;
        adv_idx        = idx_reg;
        raw_bit        = 1'b0;
        emit_raw       = 1'b0;

        if (state_reg == S_IDLE) begin
            clk_cnt_next   = '0;
            stuff_cnt_next = '0;
            lvl_next       = 1'b1;
            se0_next       = 1'b0;
            if (start) begin
                if (pid[1:0] == 2'b00 || int'(data_len) > MAX_BYTES) begin
                    error_next = 1'b1;
                end else begin
                    pid_next   = pid;
                    field_next = (pid == 4'b0101) ? frame : {endp, addr};
                    data_next  = data;
                    len_next   = data_len;
                    crc5_next  = 5'h1F;
                    crc16_next = 16'hFFFF;
                    state_next = S_SYNC;
                    idx_next   = '0;
                    // First SYNC bit is a 0, so the line leaves J for K immediately
                    lvl_next   = 1'b0;
                end
            end
        end else if (clk_cnt_reg != CNT_MAX) begin
            clk_cnt_next = clk_cnt_reg + 1'b1;
        end else begin
            clk_cnt_next = '0;
            if (is_bit_state && stuff_cnt_reg == 3'd6) begin
                // Stuffed 0: position is held so the pending raw bit goes out next
                lvl_next       = ~lvl_reg;
                stuff_cnt_next = '0;
            end else begin
                adv_idx = idx_reg + 1'b1;
                case (state_reg)
                    S_SYNC: if (idx_reg == IDX_W'(7)) begin
                        adv_state = S_PID;
                        adv_idx   = '0;
                    end
                    S_PID: if (idx_reg == IDX_W'(7)) begin
                        adv_idx = '0;
                        case (pid_reg[1:0])
                            2'b01:   adv_state = S_TOKEN;
                            2'b11:   adv_state = (len_reg == 4'd0) ? S_CRC16 : S_DATA;
                            default: adv_state = S_EOP_SE0;
                        endcase
                    end
                    S_TOKEN: if (idx_reg == IDX_W'(10)) begin
                        adv_state = S_CRC5;
                        adv_idx   = '0;
                    end
                    S_CRC5: if (idx_reg == IDX_W'(4)) begin
                        adv_state = S_EOP_SE0;
                        adv_idx   = '0;
                    end
                    S_DATA: if (int'(idx_reg) == 8 * int'(len_reg) - 1) begin
                        adv_state = S_CRC16;
                        adv_idx   = '0;
                    end
                    S_CRC16: if (idx_reg == IDX_W'(15)) begin
                        adv_state = S_EOP_SE0;
                        adv_idx   = '0;
                    end
                    S_EOP_SE0: if (idx_reg == IDX_W'(1)) begin
                        adv_state = S_EOP_J;
                        adv_idx   = '0;
                    end
                    default: begin
                        adv_state = S_IDLE;
                        adv_idx   = '0;
                    end
                endcase
                state_next = adv_state;
                idx_next   = adv_idx;

                case (adv_state)
                    S_SYNC: begin
                        raw_bit  = (adv_idx == IDX_W'(7));
                        emit_raw = 1'b1;
                    end
                    S_PID: begin
                        raw_bit  = pid_byte[adv_idx[2:0]];
                        emit_raw = 1'b1;
                    end
                    S_TOKEN: begin
                        raw_bit   = field_reg[adv_idx[3:0]];
                        emit_raw  = 1'b1;
                        crc5_next = {crc5_reg[3:0], 1'b0} ^ ((crc5_reg[4] ^ raw_bit) ? 5'h05 : 5'h00);
                    end
                    S_CRC5: begin
                        raw_bit  = ~crc5_reg[3'd4 - adv_idx[2:0]];
                        emit_raw = 1'b1;
                    end
                    S_DATA: begin
                        raw_bit    = data_reg[adv_idx[DIDX_W-1:0]];
                        emit_raw   = 1'b1;
                        crc16_next = {crc16_reg[14:0], 1'b0} ^ ((crc16_reg[15] ^ raw_bit) ? 16'h8005 : 16'h0000);
                    end
                    S_CRC16: begin
                        raw_bit  = ~crc16_reg[4'd15 - adv_idx[3:0]];
                        emit_raw = 1'b1;
                    end
                    S_EOP_SE0: se0_next = 1'b1;
                    S_EOP_J: begin
                        se0_next = 1'b0;
                        lvl_next = 1'b1;
                    end
                    default: begin
                        se0_next       = 1'b0;
                        lvl_next       = 1'b1;
                        stuff_cnt_next = '0;
                        done_next      = 1'b1;
                    end
                endcase

                if (emit_raw) begin
                    lvl_next       = raw_bit ? lvl_reg : ~lvl_reg;
                    stuff_cnt_next = raw_bit ? stuff_cnt_reg + 3'd1 : 3'd0;
                end
            end
        end
    end

    assign busy  = (state_reg != S_IDLE);
    assign oe    = busy;
    assign done  = done_reg;
    assign error = error_reg;
    assign dp_o  = ~se0_reg & (lvl_reg ^ LINE_POL);
    assign dm_o  = ~se0_reg & ~(lvl_reg ^ LINE_POL);

endmodule

// File: tb/tb_usb_sie_tx.sv
// Bench for usb_sie_tx: line decoder (NRZI + de-stuff) checked against a queue of expected raw bits.
`timescale 1ns/1ps
module tb_usb_sie_tx;
    localparam int CPB  = 4;
    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  pid = 4'b0010;
    logic [6:0]  addr = '0;
    logic [3:0]  endp = '0;
    logic [10:0] frame = '0;
    logic [63:0] data = '0;
    logic [3:0]  data_len = '0;
    logic        dp_o, dm_o, oe, busy, done, error;

    int checks = 0;
    int fails  = 0;

    bit exp_q[$];
    bit rx_bits[$];
    int cap_busy, cap_stuffed, cap_first_stuff, cap_wait;
    bit cap_eop_ok, cap_done_ok, cap_timeout, cap_stuff_err;
    bit hold_start = 1'b0;

    always #5 clk = ~clk;

    usb_sie_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start), .pid(pid), .addr(addr), .endp(endp),
        .frame(frame), .data(data), .data_len(data_len), .dp_o(dp_o), .dm_o(dm_o),
        .oe(oe), .busy(busy), .done(done), .error(error)
    );

    function automatic logic [4:0] crc5_model(input logic [10:0] f);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = (c[4] ^ f[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] crc16_model(input logic [63:0] d, input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 8 * len; i++)
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        return c;
    endfunction

    // Expected unstuffed bit stream, SYNC through last CRC bit
    task automatic push_expected(input logic [3:0] p, input logic [10:0] fld,
                                 input logic [63:0] d, input int len);
        logic [4:0]  c5;
        logic [15:0] c16;
        for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
        if (p[1:0] == 2'b01) begin
            for (int i = 0; i < 11; i++) exp_q.push_back(fld[i]);
            c5 = crc5_model(fld);
            for (int i = 4; i >= 0; i--) exp_q.push_back(~c5[i]);
        end else if (p[1:0] == 2'b11) begin
            for (int i = 0; i < 8 * len; i++) exp_q.push_back(d[i]);
            c16 = crc16_model(d, len);
            for (int i = 15; i >= 0; i--) exp_q.push_back(~c16[i]);
        end
    endtask

    // Sample one symbol per bit time, then NRZI-decode and de-stuff into rx_bits
    task automatic capture_packet();
        logic [1:0] syms[$];
        logic [1:0] prev;
        int cyc, ones, nse0;
        bit b;
        rx_bits.delete();
        cap_busy = 0; cap_stuffed = 0; cap_first_stuff = -1; cap_wait = 0;
        cap_eop_ok = 0; cap_done_ok = 0; cap_timeout = 0; cap_stuff_err = 0;
        do begin
            @(negedge clk);
            cap_wait++;
            if (!hold_start) start = 1'b0;
        end while (oe !== 1'b1 && cap_wait < 20);
        if (oe !== 1'b1) begin
            cap_timeout = 1;
            return;
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            if (cyc % CPB == 1) syms.push_back({dp_o, dm_o});
            cap_busy++;
            cyc++;
            @(negedge clk);
        end
        cap_timeout = (busy !== 1'b0);
        cap_done_ok = (done === 1'b1 && oe === 1'b0 && dp_o === 1'b1 && dm_o === 1'b0);
        prev = 2'b10;
        ones = 0;
        nse0 = 0;
        for (int k = 0; k < syms.size(); k++) begin
            if (syms[k] == 2'b00) begin
                nse0++;
            end else if (nse0 > 0) begin
                cap_eop_ok = (nse0 == 2 && syms[k] == 2'b10 && k == syms.size() - 1);
            end else begin
                b = (syms[k] == prev);
                prev = syms[k];
                if (ones == 6) begin
                    ones = 0;
                    cap_stuffed++;
                    if (cap_first_stuff < 0) cap_first_stuff = rx_bits.size();
                    if (b) cap_stuff_err = 1;
                end else begin
                    rx_bits.push_back(b);
                    ones = b ? ones + 1 : 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({oe, dp_o, dm_o, busy, done, error} !== 6'b010000) begin
            fails++;
            $display("FAIL reset_idle: got {oe,dp,dm,busy,done,error}=%b, expected 010000",
                     {oe, dp_o, dm_o, busy, done, error});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({oe, dp_o, dm_o, busy} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_release: got {oe,dp,dm,busy}=%b, expected 0100", {oe, dp_o, dm_o, busy});
        end
    endtask

    task automatic test_ack();
        bit e;
        @(negedge clk);
        pid = 4'b0010; data_len = 0; hold_start = 0;
        push_expected(pid, '0, '0, 0);
        start = 1'b1;
        capture_packet();
        checks++;
        if (rx_bits.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL ack_len: got %0d bits, expected %0d", rx_bits.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i >= rx_bits.size() || rx_bits[i] !== e) begin
                fails++;
                $display("FAIL ack_bit[%0d]: got %b, expected %b", i, (i < rx_bits.size()) ? rx_bits[i] : 1'bx, e);
            end
        end
        checks++;
        if (cap_busy !== 76) begin fails++; $display("FAIL ack_busy_cycles: got %0d, expected 76", cap_busy); end
        checks++;
        if (cap_wait !== 1) begin fails++; $display("FAIL ack_latency: got %0d cycles, expected 1", cap_wait); end
        checks++;
        if (!cap_done_ok) begin fails++; $display("FAIL ack_done: got done/oe/line not done=1 oe=0 J, expected done=1"); end
        checks++;
        if (!cap_eop_ok) begin fails++; $display("FAIL ack_eop: got malformed EOP, expected SE0 SE0 J"); end
        checks++;
        if (cap_stuffed !== 0) begin fails++; $display("FAIL ack_stuff: got %0d stuffed bits, expected 0", cap_stuffed); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL ack_done_width: got done=%b, expected 0", done); end
    endtask

    task automatic test_token(input logic [3:0] p, input logic [10:0] fld, input logic [4:0] crc_ref);
        bit e;
        logic [4:0] crc_rx;
        @(negedge clk);
        pid = p; addr = fld[6:0]; endp = fld[10:7]; frame = fld; data_len = 0;
        push_expected(p, fld, '0, 0);
        start = 1'b1;
        capture_packet();
        checks++;
        if (rx_bits.size() !== exp_q.size() || cap_timeout) begin
            fails++;
            $display("FAIL token_len: got %0d bits, expected %0d", rx_bits.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i >= rx_bits.size() || rx_bits[i] !== e) begin
                fails++;
                $display("FAIL token_bit[%0d] pid=%h: got %b, expected %b", i, p,
                         (i < rx_bits.size()) ? rx_bits[i] : 1'bx, e);
            end
        end
        crc_rx = 'x;
        if (rx_bits.size() >= 32)
            for (int i = 0; i < 5; i++) crc_rx = {crc_rx[3:0], rx_bits[27 + i]};
        checks++;
        if (crc_rx !== crc_ref) begin
            fails++;
            $display("FAIL token_crc5 pid=%h: got %h, expected %h", p, crc_rx, crc_ref);
        end
        checks++;
        if (!cap_eop_ok || !cap_done_ok) begin fails++; $display("FAIL token_eop: got bad EOP/done, expected clean end"); end
    endtask

    task automatic test_data(input logic [3:0] p, input logic [63:0] d, input int len);
        bit e;
        logic [15:0] crc_rx;
        logic [7:0]  byte0;
        @(negedge clk);
        pid = p; data = d; data_len = 4'(len);
        push_expected(p, '0, d, len);
        start = 1'b1;
        capture_packet();
        checks++;
        if (rx_bits.size() !== exp_q.size() || cap_timeout || cap_stuff_err) begin
            fails++;
            $display("FAIL data_len%0d_size: got %0d bits (stuff_err=%0d), expected %0d", len,
                     rx_bits.size(), cap_stuff_err, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i >= rx_bits.size() || rx_bits[i] !== e) begin
                fails++;
                $display("FAIL data_len%0d_bit[%0d]: got %b, expected %b", len, i,
                         (i < rx_bits.size()) ? rx_bits[i] : 1'bx, e);
            end
        end
        if (len == 0) begin
            crc_rx = 'x;
            if (rx_bits.size() >= 32)
                for (int i = 0; i < 16; i++) crc_rx = {crc_rx[14:0], rx_bits[16 + i]};
            checks++;
            if (crc_rx !== 16'h0000) begin fails++; $display("FAIL data_zero_crc: got %h, expected 0000", crc_rx); end
        end else begin
            byte0 = 'x;
            if (rx_bits.size() >= 24)
                for (int j = 0; j < 8; j++) byte0[j] = rx_bits[16 + j];
            checks++;
            if (byte0 !== d[7:0]) begin fails++; $display("FAIL data_byte0: got %h, expected %h", byte0, d[7:0]); end
            checks++;
            if (cap_first_stuff !== 22) begin
                fails++;
                $display("FAIL data_stuff_pos: got stuff after %0d raw bits, expected 22", cap_first_stuff);
            end
        end
        checks++;
        if (!cap_eop_ok || !cap_done_ok) begin fails++; $display("FAIL data_eop: got bad EOP/done, expected clean end"); end
    endtask

    task automatic test_reject(input logic [3:0] p, input logic [3:0] len);
        @(negedge clk);
        pid = p; data_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({error, busy, oe, dp_o, dm_o} !== 5'b10010) begin
            fails++;
            $display("FAIL reject pid=%h len=%0d: got {err,busy,oe,dp,dm}=%b, expected 10010", p, len,
                     {error, busy, oe, dp_o, dm_o});
        end
        @(negedge clk);
        checks++;
        if ({error, busy, oe} !== 3'b000) begin
            fails++;
            $display("FAIL reject_pulse pid=%h: got {err,busy,oe}=%b, expected 000", p, {error, busy, oe});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pid = 4'b1011; data = 64'h0123_4567_89AB_CDEF; data_len = 8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got busy=%b, expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oe, dp_o, dm_o, busy, done} !== 5'b01000) begin
            fails++;
            $display("FAIL mid_reset: got {oe,dp,dm,busy,done}=%b, expected 01000", {oe, dp_o, dm_o, busy, done});
        end
        rst = 1'b0;
        test_ack();
    endtask

    task automatic test_back_to_back();
        bit e;
        @(negedge clk);
        pid = 4'b0010; data_len = 0; hold_start = 1;
        push_expected(4'b0010, '0, '0, 0);
        start = 1'b1;
        capture_packet();
        pid = 4'b1010;
        push_expected(4'b1010, '0, '0, 0);
        hold_start = 0;
        for (int pkt = 0; pkt < 2; pkt++) begin
            if (pkt == 1) capture_packet();
            checks++;
            if (rx_bits.size() !== 16 || !cap_done_ok || !cap_eop_ok) begin
                fails++;
                $display("FAIL b2b_pkt%0d: got %0d bits done_ok=%0d eop_ok=%0d, expected 16 1 1", pkt,
                         rx_bits.size(), cap_done_ok, cap_eop_ok);
            end
            for (int i = 0; i < 16; i++) begin
                e = exp_q.pop_front();
                checks++;
                if (i >= rx_bits.size() || rx_bits[i] !== e) begin
                    fails++;
                    $display("FAIL b2b_pkt%0d_bit[%0d]: got %b, expected %b", pkt, i,
                             (i < rx_bits.size()) ? rx_bits[i] : 1'bx, e);
                end
            end
        end
        checks++;
        if (cap_wait !== 1) begin fails++; $display("FAIL b2b_gap: got %0d cycles to SYNC, expected 1", cap_wait); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_token(4'b1101, {4'hE, 7'h15}, 5'h17);
        test_token(4'b0101, 11'h710, 5'h14);
        test_data(4'b0011, 64'h0, 0);
        test_data(4'b1011, 64'hFF, 1);
        test_reject(4'b0000, 4'd0);
        test_reject(4'b0011, 4'd9);
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
